// File: rtl/ddr3_sdr_mem_model.sv
// ddr3_sdr_mem_model: cycle-based x16 DDR3 device model, one data beat per ck.
// Decodes ACT/RD/WR/PRE/REF/MRS/ZQCL and tracks the open row of each bank.
// Write bursts land in a backing store. Read bursts return after CL cycles.
// Ports: ck, rst (sync, active-high), cke, cs_n/ras_n/cas_n/we_n, ba, addr,
//        odt (ignored), dm, dq_in -> dq_out, dq_oe, err (sticky).
// Define DDR3_MODEL_CHECK_EN to enable protocol checks that drive err.
module ddr3_sdr_mem_model #(
  parameter int ROW_BITS = 14,
  parameter int COL_BITS = 10,
  parameter int MEM_BITS = 12
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [2:0]  ba,
  input  logic [15:0] addr,
  input  logic        odt,
  input  logic [1:0]  dm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        err
);

  localparam int BASE_W = ROW_BITS + COL_BITS;
  localparam int DLY    = 11;
  localparam int DEPTH  = 1 << MEM_BITS;

  typedef struct packed {
    logic              v;
    logic [BASE_W-1:0] base;
  } burst_t;

  logic [15:0] mem [DEPTH] = '{default: 16'h0000};

  logic [7:0]          bank_open;
  logic [ROW_BITS-1:0] bank_row [8];
  logic [3:0]          cl;
  logic [3:0]          cwl;

  burst_t rd_dly [DLY];
  burst_t wr_dly [DLY];

  logic              rd_act, wr_act;
  logic [2:0]        rd_cnt, wr_cnt;
  logic [BASE_W-1:0] rd_base, wr_base;

  logic              cmd_v;
  logic [2:0]        cmd;
  logic              is_act, is_rd, is_wr;
  logic              is_pre, is_ref, is_mrs;
  logic              a10;
  logic [BASE_W-1:0] cmd_base;
  logic [3:0]        cl_raw, cl_new;
  logic [3:0]        cwl_raw, cwl_new;
  logic [3:0]        rd_slot, wr_slot;

  logic              rd_go, wr_go;
  logic [BASE_W-1:0] rd_b, wr_b;
  logic [2:0]        rd_k, wr_k;
  logic [MEM_BITS-1:0] rd_idx, wr_idx;

  logic unused;
  assign unused = ^{odt, addr, is_ref};

  assign cmd_v  = cke & ~cs_n;
  assign cmd    = {ras_n, cas_n, we_n};
  assign is_act = cmd_v && (cmd == 3'b011);
  assign is_rd  = cmd_v && (cmd == 3'b101);
  assign is_wr  = cmd_v && (cmd == 3'b100);
  assign is_pre = cmd_v && (cmd == 3'b010);
  assign is_ref = cmd_v && (cmd == 3'b001);
  assign is_mrs = cmd_v && (cmd == 3'b000);
  assign a10    = addr[10];

  // A closed bank still resolves to its last activated row.
  assign cmd_base = {bank_row[ba], ba, addr[COL_BITS-1:3]};

  // Out-of-range latencies are clamped so the delay lines stay in bounds.
  assign cl_raw  = 4'(addr[6:4]) + 4'd4;
  assign cl_new  = (cl_raw < 4'd5) ? 4'd5 : cl_raw;
  assign cwl_raw = 4'(addr[5:3]) + 4'd5;
  assign cwl_new = (cwl_raw > 4'd8) ? 4'd8 : cwl_raw;

  // A burst placed at slot L-1 reaches slot 0 so that beat 0 registers
  // exactly L edges after the command edge.
  assign rd_slot = cl - 4'd1;
  assign wr_slot = cwl - 4'd1;

  always_comb begin
    rd_go  = rd_dly[0].v | rd_act;
    rd_b   = rd_dly[0].v ? rd_dly[0].base : rd_base;
    rd_k   = rd_dly[0].v ? 3'd0 : rd_cnt;
    rd_idx = MEM_BITS'({rd_b, rd_k});
    wr_go  = wr_dly[0].v | wr_act;
    wr_b   = wr_dly[0].v ? wr_dly[0].base : wr_base;
    wr_k   = wr_dly[0].v ? 3'd0 : wr_cnt;
    wr_idx = MEM_BITS'({wr_b, wr_k});
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      bank_open <= '0;
      for (int i = 0; i < 8; i++) bank_row[i] <= '0;
      cl  <= 4'd6;
      cwl <= 4'd5;
    end else begin
      if (is_act) begin
        bank_open[ba] <= 1'b1;
        bank_row[ba]  <= addr[ROW_BITS-1:0];
      end
      if (is_pre) begin
        if (a10) bank_open <= '0;
        else     bank_open[ba] <= 1'b0;
      end
      if ((is_rd || is_wr) && a10) bank_open[ba] <= 1'b0;
      if (is_mrs && ba == 3'd0) cl  <= cl_new;
      if (is_mrs && ba == 3'd2) cwl <= cwl_new;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) begin
        rd_dly[i] <= '0;
        wr_dly[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DLY - 1; i++) begin
        rd_dly[i] <= rd_dly[i+1];
        wr_dly[i] <= wr_dly[i+1];
      end
      rd_dly[DLY-1] <= '0;
      wr_dly[DLY-1] <= '0;
      if (is_rd) rd_dly[rd_slot] <= '{v: 1'b1, base: cmd_base};
      if (is_wr) wr_dly[wr_slot] <= '{v: 1'b1, base: cmd_base};
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      dq_out  <= '0;
      dq_oe   <= 1'b0;
      rd_act  <= 1'b0;
      rd_cnt  <= '0;
      rd_base <= '0;
      wr_act  <= 1'b0;
      wr_cnt  <= '0;
      wr_base <= '0;
    end else begin
      if (rd_go) begin
        dq_out  <= mem[rd_idx];
        dq_oe   <= 1'b1;
        rd_base <= rd_b;
        rd_cnt  <= rd_k + 3'd1;
        rd_act  <= (rd_k != 3'd7);
      end else begin
        dq_out <= '0;
        dq_oe  <= 1'b0;
      end
      if (wr_go) begin
        wr_base <= wr_b;
        wr_cnt  <= wr_k + 3'd1;
        wr_act  <= (wr_k != 3'd7);
      end
    end
  end

  // Non-blocking store update: a same-edge read sees the old word.
  always_ff @(posedge ck) begin
    if (!rst && wr_go) begin
      if (!dm[0]) mem[wr_idx][7:0]  <= dq_in[7:0];
      if (!dm[1]) mem[wr_idx][15:8] <= dq_in[15:8];
    end
  end

`ifdef DDR3_MODEL_CHECK_EN
  logic       err_q;
  logic [3:0] gap;

  assign err = err_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      err_q <= 1'b0;
      gap   <= 4'd8;
    end else begin
      if (is_rd || is_wr)     gap <= 4'd1;
      else if (gap != 4'd8)   gap <= gap + 4'd1;
      if ((is_rd || is_wr) && !bank_open[ba]) begin
        err_q <= 1'b1;
        $display("%0t ddr3 model: RD/WR to closed bank %0d", $time, ba);
      end
      if ((is_rd || is_wr) && gap < 4'd8) begin
        err_q <= 1'b1;
        $display("%0t ddr3 model: RD/WR spacing %0d < 8", $time, gap);
      end
      if (is_act && bank_open[ba]) begin
        err_q <= 1'b1;
        $display("%0t ddr3 model: ACT to open bank %0d", $time, ba);
      end
      if (is_ref && |bank_open) begin
        err_q <= 1'b1;
        $display("%0t ddr3 model: REF with banks open", $time);
      end
      if (is_mrs && ba == 3'd0 && addr[6:4] == 3'd0) begin
        err_q <= 1'b1;
        $display("%0t ddr3 model: illegal CL, clamped", $time);
      end
      if (is_mrs && ba == 3'd2 && addr[5]) begin
        err_q <= 1'b1;
        $display("%0t ddr3 model: illegal CWL, clamped", $time);
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_sdr_mem_model.sv
// tb_ddr3_sdr_mem_model: scoreboard bench for the DDR3 SDR memory model.
// Reference store and latency model predict every read beat and its cycle.
module tb_ddr3_sdr_mem_model;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        cs_n = 1'b1;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [15:0] addr = '0;
  logic        odt = 1'b0;
  logic [1:0]  dm = '0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        err;

  ddr3_sdr_mem_model dut (
    .ck(ck), .rst(rst), .cke(cke), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .odt(odt), .dm(dm),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .err(err)
  );

  always #5 ck = ~ck;

  typedef struct { int t; logic [15:0] d; } exp_t;
  typedef struct { int t; logic [15:0] d; logic [1:0] m; } wb_t;

  exp_t rq[$];
  wb_t  wq[$];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int run = 0;
  int last_run = 0;

  logic [15:0] mdl [4096] = '{default: 16'h0000};
  logic [13:0] row_m [8] = '{default: 14'h0};
  int cl_m = 6;
  int cwl_m = 5;
  logic [15:0] wd [8];
  logic [1:0]  wm [8];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  always @(posedge ck) begin
    #1;
    edge_n++;
    if (rq.size() > 0 && rq[0].t == edge_n) begin
      chk("rd_oe", 32'(dq_oe), 32'd1);
      chk("rd_data", 32'(dq_out), 32'(rq[0].d));
      void'(rq.pop_front());
    end else begin
      chk("idle_oe", 32'(dq_oe), 32'd0);
      chk("idle_dq", 32'(dq_out), 32'd0);
    end
    if (dq_oe) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  always @(negedge ck) begin
    if (wq.size() > 0 && wq[0].t == edge_n + 1) begin
      dq_in = wq[0].d;
      dm    = wq[0].m;
      void'(wq.pop_front());
    end else begin
      dq_in = 16'($urandom);
      dm    = 2'($urandom);
    end
  end

  function automatic int mix(logic [2:0] b, logic [9:0] col, int k);
    logic [26:0] f;
    f = {row_m[b], b, col[9:3], 3'(k)};
    return int'(f[11:0]);
  endfunction

  task automatic issue(input logic [2:0] c, input logic [2:0] b,
                       input logic [15:0] a, output int t);
    @(negedge ck);
    {ras_n, cas_n, we_n} = c;
    cs_n = 1'b0;
    ba   = b;
    addr = a;
    t    = edge_n + 1;
    @(posedge ck);
    #2;
    {ras_n, cas_n, we_n} = 3'b111;
    cs_n = 1'b1;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge ck);
    #2;
  endtask

  task automatic act(logic [2:0] b, logic [13:0] row);
    int t;
    issue(3'b011, b, {2'b00, row}, t);
    row_m[b] = row;
  endtask

  task automatic mrs(logic [2:0] b, logic [15:0] a);
    int t;
    issue(3'b000, b, a, t);
    if (b == 3'd0) cl_m  = int'(a[6:4]) + 4;
    if (b == 3'd2) cwl_m = int'(a[5:3]) + 5;
  endtask

  task automatic wr(logic [2:0] b, logic [9:0] col, logic a10);
    int t;
    int i;
    issue(3'b100, b, {5'b0, a10, col}, t);
    for (int k = 0; k < 8; k++) begin
      wq.push_back('{t: t + cwl_m + k, d: wd[k], m: wm[k]});
      i = mix(b, col, k);
      if (!wm[k][0]) mdl[i][7:0]  = wd[k][7:0];
      if (!wm[k][1]) mdl[i][15:8] = wd[k][15:8];
    end
  endtask

  task automatic rd(logic [2:0] b, logic [9:0] col, logic a10);
    int t;
    issue(3'b101, b, {5'b0, a10, col}, t);
    for (int k = 0; k < 8; k++)
      rq.push_back('{t: t + cl_m + k, d: mdl[mix(b, col, k)]});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() + wq.size()) != 0 && n < 300) begin
      @(posedge ck);
      n++;
    end
    #2;
    chk("drain", 32'(rq.size() + wq.size()), 32'd0);
    wait_cyc(2);
  endtask

  task automatic rst_pulse();
    @(negedge ck);
    rst = 1'b1;
    rq.delete();
    wq.delete();
    @(posedge ck);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) row_m[i] = '0;
    cl_m  = 6;
    cwl_m = 5;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    wait_cyc(3);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_oe", 32'(dq_oe), 32'd0);
    rst = 1'b0;

    mrs(3'd0, 16'h0020);
    mrs(3'd2, 16'h0000);
    wait_cyc(4);
    chk("mrs_err", 32'(err), 32'd0);

    act(3'd1, 14'h0123);
    wait_cyc(2);
    for (int k = 0; k < 8; k++) begin
      wd[k] = 16'h1000 + 16'(k);
      wm[k] = 2'b00;
    end
    wr(3'd1, 10'h040, 1'b0);
    wait_cyc(7);
    rd(3'd1, 10'h040, 1'b0);
    wait_idle();
    chk("burst_len", 32'(last_run), 32'd8);

    wd[3] = 16'hABCD;
    wm[3] = 2'b10;
    wr(3'd1, 10'h040, 1'b0);
    wait_cyc(7);
    rd(3'd1, 10'h040, 1'b0);
    wait_idle();
    chk("dm_merge", 32'(mdl[mix(3'd1, 10'h040, 3)]), 32'h10CD);

    for (int k = 0; k < 8; k++) begin
      wd[k] = 16'h2000 + 16'(k);
      wm[k] = 2'b00;
    end
    wr(3'd1, 10'h048, 1'b0);
    wait_cyc(7);
    rd(3'd1, 10'h040, 1'b0);
    wait_cyc(7);
    rd(3'd1, 10'h048, 1'b0);
    wait_idle();
    chk("gapless", 32'(last_run), 32'd16);

    mrs(3'd0, 16'h0070);
    mrs(3'd2, 16'h0018);
    act(3'd3, 14'h2A5A);
    for (int k = 0; k < 8; k++) begin
      wd[k] = 16'($urandom);
      wm[k] = 2'b00;
    end
    wr(3'd3, 10'h3F8, 1'b0);
    wait_cyc(7);
    rd(3'd3, 10'h3F8, 1'b1);
    wait_idle();
`ifndef DDR3_MODEL_CHECK_EN
    rd(3'd3, 10'h3F8, 1'b0);
    wait_idle();
`endif

    mrs(3'd0, 16'h0010);
    mrs(3'd2, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      wd[k] = 16'($urandom);
      wm[k] = 2'(k);
    end
    wr(3'd1, 10'h100, 1'b0);
    wait_cyc(9);
    rd(3'd1, 10'h100, 1'b0);
    wait_idle();

    cke = 1'b0;
    issue(3'b101, 3'd1, 16'h0040, t);
    cke = 1'b1;
    wait_cyc(16);
    chk("cke_err", 32'(err), 32'd0);

    rd(3'd5, 10'h000, 1'b0);
    wait_cyc(1);
`ifdef DDR3_MODEL_CHECK_EN
    chk("closed_err", 32'(err), 32'd1);
    wait_idle();
    chk("err_sticky", 32'(err), 32'd1);
`else
    chk("closed_err", 32'(err), 32'd0);
    wait_idle();
`endif

    mrs(3'd0, 16'h0020);
    rd(3'd1, 10'h040, 1'b0);
    wait_cyc(cl_m + 2);
    rst_pulse();
    wait_cyc(2);
    chk("rst_mid_oe", 32'(dq_oe), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    act(3'd1, 14'h0123);
    wait_cyc(1);
    rd(3'd1, 10'h040, 1'b0);
    wait_idle();
    chk("final_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
